// File: rtl/cf_residence_updater.sv
// rtl/cf_residence_updater.sv - PTP/PCF correctionField residence-time patcher on an 8-bit byte stream
module cf_residence_updater #(
    parameter int TIME_WIDTH    = 64,
    parameter int DELAY         = 8,
    parameter int PTP_CF_OFFSET = 30,
    parameter int PCF_CF_OFFSET = 42,
    parameter int ASYM_WIDTH    = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [7:0]            iv_data,
    input  logic                  i_data_wr,
    input  logic [TIME_WIDTH-1:0] iv_receive_time,
    input  logic [TIME_WIDTH-1:0] iv_local_time,
    input  logic                  i_cf_update_flag,
    input  logic                  i_tsn_or_tte,
    input  logic [ASYM_WIDTH-1:0] iv_asym_ns,
    output logic [7:0]            ov_data,
    output logic                  o_data_wr,
    output logic                  o_cf_updated,
    output logic                  o_short_pkt,
    output logic                  o_ts_err
);
    localparam logic [10:0] PTP_OFF = 11'(PTP_CF_OFFSET);
    localparam logic [10:0] PCF_OFF = 11'(PCF_CF_OFFSET);
    localparam logic [10:0] CNT_MAX = 11'd2047;

    typedef struct packed {
        logic       vld;
        logic       first;
        logic       upd;
        logic       mode;
        logic [7:0] data;
    } lane_t;

    typedef enum logic [2:0] {IDLE, PASS, COLLECT, PATCH, DRAIN_SHORT} state_t;

    // input side: frame context and CF capture
    logic                  armed, prev_wr, upd_l, mode_l;
    logic [ASYM_WIDTH-1:0] asym_l, cur_asym;
    logic [10:0]           icnt, idx, off_in, off_l;
    logic [55:0]           cf_sr;
    logic [63:0]           cfw, new_cf;
    logic                  vld_in, first_in, cur_upd, cur_mode, hit, short_end, push;
    logic [TIME_WIDTH-1:0] res;
    logic                  res_bad;
    logic [49:0]           ns_sum;
    logic [47:0]           ns_sat;

    always_comb begin
        vld_in    = i_data_wr & armed;
        first_in  = vld_in & ~prev_wr;
        idx       = first_in ? 11'd0 : ((icnt == CNT_MAX) ? CNT_MAX : icnt + 11'd1);
        cur_upd   = first_in ? i_cf_update_flag : upd_l;
        cur_mode  = first_in ? i_tsn_or_tte : mode_l;
        cur_asym  = first_in ? iv_asym_ns : asym_l;
        off_in    = cur_mode ? PTP_OFF : PCF_OFF;
        off_l     = mode_l ? PTP_OFF : PCF_OFF;
        cfw       = {cf_sr, iv_data};
        res       = iv_local_time - iv_receive_time;
        res_bad   = |res[TIME_WIDTH-1:47];
        // 50-bit sum cannot overflow; saturate when bits 49..47 disagree
        ns_sum    = {{2{cfw[63]}}, cfw[63:16]} + {3'b000, res[46:0]}
                  + {{(50-ASYM_WIDTH){cur_asym[ASYM_WIDTH-1]}}, cur_asym};
        if (ns_sum[49:47] == 3'b000 || ns_sum[49:47] == 3'b111)
            ns_sat = ns_sum[47:0];
        else
            ns_sat = ns_sum[49] ? 48'h8000_0000_0000 : 48'h7FFF_FFFF_FFFF;
        new_cf    = res_bad ? cfw : {ns_sat, cfw[15:0]};
        hit       = vld_in & cur_upd & (idx == off_in + 11'd7);
        short_end = prev_wr & ~vld_in & upd_l & (icnt < off_l + 11'd7);
        push      = hit | short_end;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            armed   <= 1'b0;
            prev_wr <= 1'b0;
            icnt    <= '0;
            upd_l   <= 1'b0;
            mode_l  <= 1'b0;
            asym_l  <= '0;
            cf_sr   <= '0;
        end else begin
            // after reset, bytes are ignored until the stream has gone idle once
            armed   <= armed | ~i_data_wr;
            prev_wr <= vld_in;
            icnt    <= vld_in ? idx : 11'd0;
            if (first_in) begin
                upd_l  <= i_cf_update_flag;
                mode_l <= i_tsn_or_tte;
                asym_l <= iv_asym_ns;
            end
            if (vld_in)
                cf_sr <= cfw[55:0];
        end
    end

    // per-frame results, one entry per update frame, consumed by the output side
    logic [1:0]  q_cnt;
    logic        q_wp, q_rp, pop;
    logic        q_short [2];
    logic        q_err [2];
    logic [63:0] q_cf [2];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            q_cnt <= '0;
            q_wp  <= 1'b0;
            q_rp  <= 1'b0;
        end else begin
            q_cnt <= q_cnt + 2'(push) - 2'(pop);
            if (push) q_wp <= ~q_wp;
            if (pop)  q_rp <= ~q_rp;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            q_short[q_wp] <= short_end;
            q_err[q_wp]   <= res_bad;
            q_cf[q_wp]    <= new_cf;
        end
    end

    // delay line and output stage
    lane_t       dl [DELAY];
    lane_t       s;
    logic        nx_vld, s_last, patch_end;
    logic [10:0] ocnt, pos, off_out;
    logic [2:0]  sel;
    logic [63:0] head_cf;
    logic [7:0]  patch_byte;
    state_t      st, cur;

    always_comb begin
        s          = dl[DELAY-1];
        nx_vld     = dl[DELAY-2].vld;
        s_last     = s.vld & ~nx_vld;
        pos        = s.first ? 11'd0 : ((ocnt == CNT_MAX) ? CNT_MAX : ocnt + 11'd1);
        off_out    = s.mode ? PTP_OFF : PCF_OFF;
        sel        = 3'(pos - off_out);
        head_cf    = q_cf[q_rp];
        patch_byte = 8'(head_cf >> {~sel, 3'b000});
        cur        = st;
        if (s.first)
            cur = s.upd ? COLLECT : PASS;
        if (cur == COLLECT && q_cnt != 2'd0)
            cur = q_short[q_rp] ? DRAIN_SHORT : ((pos == off_out) ? PATCH : COLLECT);
        patch_end  = (cur == PATCH) && (sel == 3'd7);
        pop        = s.vld & (patch_end | ((cur == DRAIN_SHORT) & s_last));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DELAY; i++)
                dl[i] <= '0;
            st           <= IDLE;
            ocnt         <= '0;
            ov_data      <= '0;
            o_data_wr    <= 1'b0;
            o_cf_updated <= 1'b0;
            o_short_pkt  <= 1'b0;
            o_ts_err     <= 1'b0;
        end else begin
            dl[0] <= {vld_in, first_in, cur_upd, cur_mode, (vld_in ? iv_data : 8'h00)};
            for (int i = 1; i < DELAY; i++)
                dl[i] <= dl[i-1];
            o_data_wr    <= s.vld;
            ov_data      <= s.data;
            o_cf_updated <= 1'b0;
            o_short_pkt  <= 1'b0;
            o_ts_err     <= 1'b0;
            ocnt         <= s.vld ? pos : 11'd0;
            if (s.vld) begin
                if (cur == PATCH)
                    ov_data <= patch_byte;
                o_cf_updated <= patch_end & ~q_err[q_rp];
                o_ts_err     <= patch_end & q_err[q_rp];
                o_short_pkt  <= (cur == DRAIN_SHORT) & s_last;
                if (s_last)
                    st <= IDLE;
                else if (patch_end)
                    st <= PASS;
                else
                    st <= cur;
            end
        end
    end
endmodule

// File: tb/tb_cf_residence_updater.sv
// tb/tb_cf_residence_updater.sv - directed self-checking bench for cf_residence_updater
module tb_cf_residence_updater;
    logic        clk = 1'b0;
    logic        rst_n, wr, upd, tte;
    logic [7:0]  data;
    logic [63:0] rx_t, loc_t;
    logic [31:0] asym;
    logic [7:0]  odata;
    logic        owr, cfu, shp, tse;

    cf_residence_updater dut (
        .i_clk(clk), .i_rst_n(rst_n), .iv_data(data), .i_data_wr(wr),
        .iv_receive_time(rx_t), .iv_local_time(loc_t),
        .i_cf_update_flag(upd), .i_tsn_or_tte(tte), .iv_asym_ns(asym),
        .ov_data(odata), .o_data_wr(owr), .o_cf_updated(cfu),
        .o_short_pkt(shp), .o_ts_err(tse)
    );

    always #4 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // captured output: {ts_err, short, cf_updated, byte} per valid byte
    logic [10:0] oq [$];
    int          ocq [$];
    int          stray = 0;
    always @(negedge clk) begin
        if (owr) begin
            oq.push_back({tse, shp, cfu, odata});
            ocq.push_back(cyc);
        end else if (cfu | shp | tse) begin
            stray++;
        end
    end

    int          npass = 0, ntot = 0, in_start = 0, b = 0;
    logic [7:0]  fr [0:255];
    logic [10:0] ex [0:255];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ntot++;
        assert (got === exp) npass++;
        else $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    endtask

    task automatic fill(input int len, input int seed);
        for (int i = 0; i < len; i++) begin
            fr[i] = 8'(i * 7 + seed);
            ex[i] = {3'b000, 8'(i * 7 + seed)};
        end
    endtask

    task automatic put_cf(input int off, input logic [63:0] v, input logic [63:0] e, input logic [2:0] flg);
        for (int k = 0; k < 8; k++) begin
            fr[off+k] = v[63-8*k -: 8];
            ex[off+k] = {3'b000, e[63-8*k -: 8]};
        end
        ex[off+7][10:8] = flg;
    endtask

    task automatic send(input int len);
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            data = fr[i];
            wr   = 1'b1;
            if (i == 0) in_start = cyc;
        end
        @(posedge clk); #1;
        wr   = 1'b0;
        data = 8'h00;
    endtask

    task automatic check_frame(input int base, input int len, input string tag);
        chk($sformatf("%s_len", tag), 64'(oq.size() - base), 64'(len));
        for (int i = 0; i < len; i++)
            if (base + i < oq.size())
                chk($sformatf("%s_b%0d", tag, i), 64'(oq[base+i]), 64'(ex[i]));
    endtask

    initial begin
        rst_n = 1'b0; wr = 1'b0; data = 8'h00; upd = 1'b0; tte = 1'b1;
        rx_t = '0; loc_t = '0; asym = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_wr", 64'(owr), 64'd0);
        chk("reset_data", 64'(odata), 64'd0);
        chk("reset_pulses", 64'({cfu, shp, tse}), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // PTP frame: 100 ns CF + 500 ns residence
        upd = 1'b1; tte = 1'b1; rx_t = 64'd1000; loc_t = 64'd1500; asym = 32'd0;
        fill(64, 1);
        put_cf(30, 64'h0000_0000_0064_0000, 64'h0000_0000_0258_0000, 3'b001);
        b = oq.size();
        send(64);
        repeat (16) @(posedge clk);
        check_frame(b, 64, "ptp");
        chk("ptp_latency", (ocq.size() > b) ? 64'(ocq[b] - in_start) : 64'hFFFF, 64'd9);

        // PCF frame, receive time wraps, negative asymmetry
        upd = 1'b1; tte = 1'b0; rx_t = 64'hFFFF_FFFF_FFFF_FFF0; loc_t = 64'h10; asym = 32'hFFFF_FFF8;
        fill(60, 5);
        put_cf(42, 64'h0000_0000_0000_1234, 64'h0000_0000_0018_1234, 3'b001);
        b = oq.size();
        send(60);
        repeat (16) @(posedge clk);
        check_frame(b, 60, "pcf");

        // positive saturation, sub-ns kept
        upd = 1'b1; tte = 1'b1; rx_t = 64'd1000; loc_t = 64'd1256; asym = 32'd0;
        fill(50, 2);
        put_cf(30, 64'h7FFF_FFFF_FFF0_ABCD, 64'h7FFF_FFFF_FFFF_ABCD, 3'b001);
        b = oq.size();
        send(50);
        repeat (16) @(posedge clk);
        check_frame(b, 50, "satpos");

        // negative saturation
        upd = 1'b1; tte = 1'b1; rx_t = 64'd7; loc_t = 64'd7; asym = 32'hFFFF_FFE0;
        fill(48, 4);
        put_cf(30, 64'h8000_0000_0010_5555, 64'h8000_0000_0000_5555, 3'b001);
        b = oq.size();
        send(48);
        repeat (16) @(posedge clk);
        check_frame(b, 48, "satneg");

        // short update frame ends before byte 37
        upd = 1'b1; tte = 1'b1; rx_t = 64'd0; loc_t = 64'd9; asym = 32'd0;
        fill(34, 9);
        ex[33] = ex[33] | 11'h200;
        b = oq.size();
        send(34);
        repeat (16) @(posedge clk);
        check_frame(b, 34, "short");

        // non-update frame, 1-cycle gap, then update frame
        upd = 1'b0; tte = 1'b1; rx_t = 64'd0; loc_t = 64'd5; asym = 32'd3;
        fill(100, 3);
        b = oq.size();
        send(100);
        upd = 1'b1;
        fill(64, 6);
        put_cf(30, 64'h0000_0000_0010_0001, 64'h0000_0000_0018_0001, 3'b001);
        send(64);
        repeat (16) @(posedge clk);
        chk("plain_len", 64'(oq.size() - b), 64'd164);
        for (int i = 0; i < 100; i++)
            if (b + i < oq.size())
                chk($sformatf("plain_b%0d", i), 64'(oq[b+i]), {53'd0, 3'b000, 8'(i * 7 + 3)});
        check_frame(b + 100, 64, "after_gap");
        chk("gap_kept", (ocq.size() > b + 100) ? 64'(ocq[b+100] - ocq[b+99]) : 64'hFFFF, 64'd2);

        // reset in the middle of an update frame
        upd = 1'b1; tte = 1'b1; rx_t = 64'd0; loc_t = 64'd50; asym = 32'd0;
        fill(64, 11);
        for (int i = 0; i <= 20; i++) begin
            @(posedge clk); #1;
            data = fr[i];
            wr   = 1'b1;
        end
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_wr", 64'(owr), 64'd0);
        chk("midrst_data", 64'(odata), 64'd0);
        chk("midrst_pulses", 64'({cfu, shp, tse}), 64'd0);
        b = oq.size();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            data = fr[21];
        end
        @(posedge clk); #1;
        wr = 1'b0;
        repeat (20) @(posedge clk);
        chk("midrst_discard", 64'(oq.size() - b), 64'd0);

        // local time behind receive time by 2^50: CF untouched, ts_err
        upd = 1'b1; tte = 1'b1; rx_t = 64'h0004_0000_0000_0064; loc_t = 64'd100; asym = 32'd0;
        fill(64, 13);
        put_cf(30, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 3'b100);
        b = oq.size();
        send(64);
        repeat (16) @(posedge clk);
        check_frame(b, 64, "tserr");
        chk("stray_pulses", 64'(stray), 64'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
